// File: rtl/cipher_serializer_pkg.sv
// Shared definitions for the cipher word serializer: FSM encoding, frame geometry
// and byte-index width.
package cipher_serializer_pkg;

  localparam int BYTES_PER_FRAME = 16;
  localparam int CIPHER_W        = 128;
  localparam int IDX_W           = $clog2(BYTES_PER_FRAME);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/cipher_byte_mux.sv
// Combinational byte selector: returns byte k of the held cipher word, where
// bit 0 of the word (its first bit) lands on o_byte[7].
module cipher_byte_mux
  import cipher_serializer_pkg::*;
(
  input  logic [0:CIPHER_W-1] i_word,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [7:0]          o_byte
);

  assign o_byte = i_word[{i_idx, 3'b000} +: 8];

endmodule

// File: rtl/cipher_serializer.sv
// Splits a 128-bit cipher word into 16 bytes, first cipher bit first, with an
// optional idle gap between bytes. Define CIPHER_SER_KAT_EN for the known-answer check.
module cipher_serializer
  import cipher_serializer_pkg::*;
#(
  parameter int           GAP_CYCLES = 0,
  parameter logic [127:0] KAT_VALUE  = 128'h0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
`ifdef CIPHER_SER_KAT_EN
  output logic          kat_done,
  output logic          kat_match,
`endif
  output logic          busy
);

  localparam bit                NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [7:0]        GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_gap;
  logic [0:CIPHER_W-1]   r_hold;
  logic [7:0]            w_byte;
  logic                  w_capture;
  logic                  w_accept;

  assign w_capture = in_valid && (r_state == ST_IDLE);
  assign w_accept  = out_ready && (r_state == ST_SEND);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) w_state_nxt = ST_IDLE;
          else if (!NO_GAP)      w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  if (r_gap == 8'd0) w_state_nxt = ST_SEND;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = w_byte;
        out_last  = (r_idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Index advances on acceptance (no gap) or when the gap expires; both saturate.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_idx <= '0;
      r_gap <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) r_idx <= '0;
        ST_SEND: begin
          if (w_accept && (r_idx != LAST_IDX)) begin
            if (NO_GAP) r_idx <= r_idx + 1'b1;
            else        r_gap <= GAP_INIT;
          end
        end
        ST_GAP: begin
          if (r_gap == 8'd0) begin
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Holding register is pure data: it only changes on capture and needs no reset.
  always_ff @(posedge sys_clk) begin
    if (w_capture) r_hold <= in_data;
  end

  cipher_byte_mux u_byte_mux (
    .i_word (r_hold),
    .i_idx  (r_idx),
    .o_byte (w_byte)
  );

`ifdef CIPHER_SER_KAT_EN
  logic r_kat_done;
  logic r_kat_match;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_kat_done  <= 1'b0;
      r_kat_match <= 1'b0;
    end else begin
      r_kat_done <= w_capture;
      if (w_capture) r_kat_match <= (in_data == KAT_VALUE);
    end
  end

  assign kat_done  = r_kat_done;
  assign kat_match = r_kat_match;
`endif

endmodule

// File: tb/tb_cipher_serializer.sv
// Directed bench for cipher_serializer: one instance with no gap, one with a
// two-cycle gap; KAT checks are compiled in when CIPHER_SER_KAT_EN is defined.
module tb_cipher_serializer;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [0:127] in_data;
  logic [7:0]   out_data;
  logic         g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_out_last, g_busy;
  logic [0:127] g_in_data;
  logic [7:0]   g_out_data;
`ifdef CIPHER_SER_KAT_EN
  logic         kat_done, kat_match, g_kat_done, g_kat_match;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] W_INC = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] W_ONE = {128{1'b1}};

  always #5 sys_clk = ~sys_clk;

  cipher_serializer #(.GAP_CYCLES(0), .KAT_VALUE(128'h0)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef CIPHER_SER_KAT_EN
    .kat_done  (kat_done),
    .kat_match (kat_match),
`endif
    .busy      (busy)
  );

  cipher_serializer #(.GAP_CYCLES(2), .KAT_VALUE(128'h0)) dut_g (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (g_in_valid),
    .in_ready  (g_in_ready),
    .in_data   (g_in_data),
    .out_valid (g_out_valid),
    .out_ready (g_out_ready),
    .out_data  (g_out_data),
    .out_last  (g_out_last),
`ifdef CIPHER_SER_KAT_EN
    .kat_done  (g_kat_done),
    .kat_match (g_kat_match),
`endif
    .busy      (g_busy)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Present a word for one cycle from a negedge; returns at the negedge showing byte 0.
  task automatic start(input logic [127:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  // Expected byte k is the k-th byte counted from the most significant end.
  function automatic logic [7:0] exp_byte(input logic [127:0] w, input int k);
    return 8'(w >> (8 * (15 - k)));
  endfunction

  task automatic stream(input logic [127:0] w, input int stall_idx, input int stall_n);
    for (int k = 0; k < 16; k++) begin
      check_val("byte_vld",  out_valid, 1);
      check_val("byte_data", out_data, exp_byte(w, k));
      check_val("byte_last", out_last, (k == 15));
      check_val("busy_rdy",  in_ready, 0);
      if (k == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge sys_clk);
          check_val("stall_vld",  out_valid, 1);
          check_val("stall_data", out_data, exp_byte(w, k));
          check_val("stall_last", out_last, (k == 15));
        end
        out_ready = 1'b1;
      end
      @(negedge sys_clk);
    end
    check_val("end_rdy",  in_ready, 1);
    check_val("end_vld",  out_valid, 0);
    check_val("end_busy", busy, 0);
  endtask

  initial begin
    int caps, t0, t1, nb, run, cyc;
    sys_rst     = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    g_in_valid  = 1'b0;
    g_in_data   = '0;
    g_out_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    check_val("rst_rdy",  in_ready, 1);
    check_val("rst_vld",  out_valid, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_data", out_data, 8'h00);
`ifdef CIPHER_SER_KAT_EN
    check_val("rst_kdone",  kat_done, 0);
    check_val("rst_kmatch", kat_match, 0);
`endif

    // Back-to-back frame, no stalls
    start(W_INC);
    stream(W_INC, -1, 0);

    // Byte 5 stalled for three cycles
    start(W_INC);
    stream(W_INC, 5, 3);

    // Reset right after byte 7 is accepted
    start(W_SEQ);
    for (int k = 0; k < 8; k++) begin
      check_val("pre_rst_data", out_data, exp_byte(W_SEQ, k));
      @(negedge sys_clk);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_val("mid_rst_vld",  out_valid, 0);
    check_val("mid_rst_rdy",  in_ready, 1);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_last", out_last, 0);
    check_val("mid_rst_data", out_data, 8'h00);
    start(W_SEQ);
    stream(W_SEQ, -1, 0);

    // in_valid held across two frames
    caps = 0; t0 = 0; t1 = 0;
    in_valid = 1'b1;
    in_data  = W_INC;
    for (int i = 0; i < 34; i++) begin
      if (in_ready) begin
        caps++;
        if (caps == 1) t0 = i;
        else           t1 = i;
      end
      @(negedge sys_clk);
    end
    in_valid = 1'b0;
    check_val("hold_caps",    caps, 2);
    check_val("hold_spacing", t1 - t0, 17);
    check_val("hold_idle",    busy, 0);

`ifdef CIPHER_SER_KAT_EN
    start(128'h0);
    check_val("kat0_done",  kat_done, 1);
    check_val("kat0_match", kat_match, 1);
    stream(128'h0, -1, 0);
    check_val("kat0_done_clr", kat_done, 0);
    check_val("kat0_hold",     kat_match, 1);
    start(128'h1);
    check_val("kat1_done",  kat_done, 1);
    check_val("kat1_match", kat_match, 0);
    stream(128'h1, -1, 0);
    check_val("kat1_hold",  kat_match, 0);
`endif

    // Two-cycle gap instance, all-ones word
    g_in_valid = 1'b1;
    g_in_data  = W_ONE;
    @(negedge sys_clk);
    g_in_valid = 1'b0;
    nb = 0; run = 0; cyc = 0;
    check_val("gap_first_vld", g_out_valid, 1);
    while (nb < 16 && cyc < 80) begin
      if (g_out_valid) begin
        check_val("gap_data", g_out_data, 8'hFF);
        check_val("gap_last", g_out_last, (nb == 15));
        if (nb > 0) check_val("gap_len", run, 2);
        nb++;
        run = 0;
      end else begin
        check_val("gap_rdy", g_in_ready, 0);
        run++;
      end
      cyc++;
      @(negedge sys_clk);
    end
    check_val("gap_bytes", nb, 16);
    check_val("gap_end_rdy",  g_in_ready, 1);
    check_val("gap_end_busy", g_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cipher_serializer.md
CIPHER_SERIALIZER -- requirements
Module: cipher_serializer

Interface
REQ-001 Parameter GAP_CYCLES, default 0: idle cycles inserted between consecutive output bytes, legal range 0..255.
REQ-002 Parameter KAT_VALUE, default 128'h0: known-answer word for the KAT feature; ignored without the macro in REQ-024.
REQ-003 Port sys_clk  input  1: single clock, all logic on rising edge.
REQ-004 Port sys_rst  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: cipher word available from the encryption stage.
REQ-006 Port in_ready  output  1: block can accept a word.
REQ-007 Port in_data  input  [0:127]: cipher word; bit 0 is the first, most significant cipher bit.
REQ-008 Port out_valid  output  1: out_data holds a valid byte.
REQ-009 Port out_ready  input  1: downstream accepts the byte.
REQ-010 Port out_data  output  8: current byte.
REQ-011 Port out_last  output  1: current byte is byte 15 of the frame.
REQ-012 Port busy  output  1: a frame is in progress (state not IDLE).
REQ-013 Ports kat_done / kat_match  output  1 each: present only with the macro in REQ-024.

Function
REQ-014 The FSM SHALL have states IDLE, SEND and GAP.
- IDLE: in_ready=1, out_valid=0.
- SEND: out_valid=1.
- GAP: out_valid=0, in_ready=0.
REQ-015 IDLE: on in_valid&&in_ready, capture in_data into a 128-bit holding register, set byte index to 0, go to SEND. out_valid rises the cycle after capture (latency 1).
REQ-016 Byte k (0..15) SHALL equal in_data[8k:8k+7], with in_data[8k] on out_data[7]. Byte 0 goes first.
REQ-017 SEND: on out_valid&&out_ready with index<15:
- GAP_CYCLES=0: increment the index and stay in SEND (back-to-back bytes).
- GAP_CYCLES>0: go to GAP for exactly GAP_CYCLES cycles, then SEND with index+1.
REQ-018 SEND: on out_valid&&out_ready with index==15, go to IDLE. in_ready is 1 from the following cycle, never in the same cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_last SHALL stay stable for any number of cycles.
REQ-020 out_last=1 only while out_valid=1 and index==15.
REQ-021 in_valid during SEND or GAP SHALL be ignored. Upstream holds in_valid/in_data until accepted; no word is lost or duplicated.
REQ-022 The byte index and gap counter SHALL never wrap: the index stops at 15 and the gap counter stops at 0.

Reset
REQ-023 sys_rst=1 at a clock edge, in any state including mid-frame, SHALL give the following on the next cycle: state IDLE, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=8'h00, index=0, gap counter=0, kat_done=0, kat_match=0. Any partial frame is discarded, not resumed.

Configuration
REQ-024 With CIPHER_SER_KAT_EN defined:
- On each capture, compare in_data with KAT_VALUE.
- The cycle after capture: kat_done pulses 1 for one cycle, and kat_match is set to the comparison result.
- kat_match holds until the next capture or reset.
Without CIPHER_SER_KAT_EN: no comparator and no kat_* ports; all other behaviour is identical.

Structure
REQ-025 A shared package SHALL hold: the FSM state encoding, the constants BYTES_PER_FRAME=16 and CIPHER_W=128, and the byte-index width.
REQ-026 One sub-module SHALL be used: cipher_byte_mux (combinational selection of byte k from the 128-bit holding register). The FSM and counters stay in cipher_serializer.

Verification
REQ-027 in_data=128'h00112233445566778899AABBCCDDEEFF, out_ready=1, GAP_CYCLES=0: out_data is 00,11,…,FF on 16 consecutive cycles starting one cycle after capture; out_last=1 only on FF; in_ready=1 the cycle after.
REQ-028 Same word, out_ready=0 for 3 cycles while byte 5 is presented: out_data holds 8'h55 for 4 cycles, and the remaining sequence is unchanged.
REQ-029 GAP_CYCLES=2, word 128'hFF…FF: 16 bytes of 8'hFF, with out_valid low for exactly 2 cycles between each pair of bytes.
REQ-030 sys_rst=1 for 1 cycle right after byte 7 is accepted: the next cycle has out_valid=0, in_ready=1 and busy=0. A new word then starts again from byte 0.
REQ-031 CIPHER_SER_KAT_EN defined, KAT_VALUE=128'h0:
- in_data=0 → kat_done pulse with kat_match=1.
- Next word 128'h1 → kat_done pulse with kat_match=0.
REQ-032 in_valid held high throughout two frames: exactly two captures, separated by the 16-byte frame plus 1 idle cycle.
